// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES SubBytes / InvSubBytes engine.
// A 128-bit state is accepted on a valid/ready handshake, pushed through
// BYTES_PER_CYCLE sbox instances per clock (16/BYTES_PER_CYCLE clocks in total)
// and handed downstream on a second valid/ready handshake.
// Optional build macro: SUBBYTES_SELFCHECK_EN. When defined, every substituted
// byte is re-mapped through an opposite-direction sbox and compared with its
// source byte; any disagreement sets the sticky err output. When undefined,
// no checker is built and err is tied low.

// Single combinational sbox. ctrl = 0 gives the forward AES sbox, ctrl = 1
// gives the inverse sbox. Both directions share one GF(2^8) inverter, which
// uses the GF(2^4) subfield: a^17 always lies in GF(2^4), so its inverse is
// (a^17)^14 and the full inverse is a^16 * (a^17)^14 = a^254.
module sub_bytes_sbox (
  input  logic [7:0] din,
  input  logic       ctrl,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a4, a8, a16;
    logic [7:0] t, t2, t4, t8;
    a2  = gf_mul(a, a);
    a4  = gf_mul(a2, a2);
    a8  = gf_mul(a4, a4);
    a16 = gf_mul(a8, a8);
    t   = gf_mul(a16, a);
    t2  = gf_mul(t, t);
    t4  = gf_mul(t2, t2);
    t8  = gf_mul(t4, t4);
    return gf_mul(a16, gf_mul(gf_mul(t2, t4), t8));
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre_inv;
  logic [7:0] post_inv;

  // Forward: invert then affine. Inverse: undo the affine then invert.
  always_comb begin
    pre_inv  = ctrl ? inv_affine(din) : din;
    post_inv = gf_inv(pre_inv);
    dout     = ctrl ? post_inv : affine(post_inv);
  end

endmodule

module sub_bytes_serial #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic         err
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int W  = 8 * BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [127:0]    work;
  logic [CW-1:0]   cnt;
  logic            mode;
  logic            last;
  logic [6:0]      lo_bit;
  logic [W-1:0]    sel_bytes;
  logic [W-1:0]    sub_bytes;

  assign last   = (cnt == CW'(N - 1));
  assign lo_bit = 7'(cnt) * 7'(W);

  // Pick the group of bytes that this RUN cycle substitutes.
  always_comb begin
    sel_bytes = work[lo_bit +: W];
  end

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    sub_bytes_sbox u_sbox (
      .din  (sel_bytes[8*i +: 8]),
      .ctrl (mode),
      .dout (sub_bytes[8*i +: 8])
    );
  end

  // State register for the IDLE / RUN / DONE controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode: accept in IDLE, walk the byte groups in RUN, hold in DONE until taken.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Working register, captured mode and group counter; substituted bytes are written back in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            mode <= in_mode;
            cnt  <= '0;
          end
        end
        RUN: begin
          work[lo_bit +: W] <= sub_bytes;
          cnt               <= last ? '0 : cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_state = work;

`ifdef SUBBYTES_SELFCHECK_EN
  logic [W-1:0] chk_bytes;
  logic         chk_fail;
  logic         err_q;

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_check
    sub_bytes_sbox u_check (
      .din  (sub_bytes[8*i +: 8]),
      .ctrl (~mode),
      .dout (chk_bytes[8*i +: 8])
    );
  end

  // A correct substitution mapped back the other way must reproduce the source bytes.
  always_comb begin
    chk_fail = (chk_bytes != sel_bytes);
  end

  // Sticky error: cleared on accept, set by any checker disagreement while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      err_q <= 1'b0;
    end else if ((state == RUN) && chk_fail) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: self-checking bench for sub_bytes_serial.
// Three instances (BYTES_PER_CYCLE = 1, 4, 16) are exercised with a table of
// known AES vectors, randomized blocks against a table-lookup reference model,
// a backpressure sequence and a mid-run reset.
module tb_sub_bytes_serial;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_mode   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];
  logic         err       [3];

  int total;
  int bad;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  typedef struct {
    logic [127:0] st;
    logic         md;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [9];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_bytes_serial #(
      .BYTES_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 4 : 16))
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_mode   (in_mode[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    int y;
    p = 0;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] ref_rot(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Reference tables: multiplicative inverse by exhaustive search, then the FIPS-197 affine map.
  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ ref_rot(inv, 1) ^ ref_rot(inv, 2) ^ ref_rot(inv, 3) ^ ref_rot(inv, 4) ^ 8'h63;
      fwd_tbl[a] = s;
      inv_tbl[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic md);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = md ? inv_tbl[st[8*i +: 8]] : fwd_tbl[st[8*i +: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Offer one block on instance k; returns at the negedge just after the accept edge.
  task automatic applyStimulus(input int k, input logic [127:0] st, input logic md, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[k]) timeoutFail({name, "/accept"});
    in_state[k] = st;
    in_mode[k]  = md;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic waitResult(input int k, output int lat, input string name);
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[k]) timeoutFail({name, "/result"});
  endtask

  task automatic drain(input int k, input string name);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    checkOutput({name, "/valid_drop"}, 128'(out_valid[k]), 128'(0));
    checkOutput({name, "/ready_back"}, 128'(in_ready[k]), 128'(1));
  endtask

  task automatic runBlock(input int k, input logic [127:0] st, input logic md,
                          input logic [127:0] exp, input string name, input int hold);
    int lat;
    applyStimulus(k, st, md, name);
    waitResult(k, lat, name);
    checkOutput({name, "/latency"}, 128'(lat), 128'(n_of(k)));
    checkOutput({name, "/state"}, out_state[k], exp);
    checkOutput({name, "/err"}, 128'(err[k]), 128'(0));
    repeat (hold) @(negedge clk);
    drain(k, name);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int seen;
    logic [127:0] got;
    logic [127:0] st;
    logic md;

    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      in_mode[k]   = 1'b0;
      out_ready[k] = 1'b0;
    end
    buildTables();

    vecs[0] = '{st: 128'h0, md: 1'b0, exp: {16{8'h63}}};
    vecs[1] = '{st: 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19, md: 1'b0,
                exp: 128'h3052411e_e55db4b8_f198bfe0_ae1127d4};
    vecs[2] = '{st: 128'h3052411e_e55db4b8_f198bfe0_ae1127d4, md: 1'b1,
                exp: 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19};
    vecs[3] = '{st: {16{8'h53}}, md: 1'b0, exp: {16{8'hed}}};
    vecs[4] = '{st: {16{8'hed}}, md: 1'b1, exp: {16{8'h53}}};
    vecs[5] = '{st: {16{8'h63}}, md: 1'b1, exp: 128'h0};
    vecs[6] = '{st: {16{8'h01}}, md: 1'b0, exp: {16{8'h7c}}};
    vecs[7] = '{st: 128'h0, md: 1'b1, exp: {16{8'h52}}};
    vecs[8] = '{st: 128'h0f0e0d0c_0b0a0908_07060504_03020100, md: 1'b0,
                exp: 128'h76abd7fe_2b670130_c56f6bf2_7b777c63};

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset/k%0d/in_ready", k), 128'(in_ready[k]), 128'(1));
      checkOutput($sformatf("reset/k%0d/out_valid", k), 128'(out_valid[k]), 128'(0));
      checkOutput($sformatf("reset/k%0d/busy", k), 128'(busy[k]), 128'(0));
      checkOutput($sformatf("reset/k%0d/err", k), 128'(err[k]), 128'(0));
      checkOutput($sformatf("reset/k%0d/out_state", k), out_state[k], 128'(0));
    end
    rst_n = 1'b1;

    $display("[TB] busy window with out_ready tied high");
    out_ready[0] = 1'b1;
    applyStimulus(0, 128'h0, 1'b0, "busy");
    busy_cnt = 0;
    lat      = -1;
    got      = '0;
    for (int c = 0; c < 100; c++) begin
      if (!busy[0]) break;
      busy_cnt++;
      if (out_valid[0] && lat < 0) begin
        lat = c;
        got = out_state[0];
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b0;
    checkOutput("busy/cycles", 128'(busy_cnt), 128'(17));
    checkOutput("busy/latency", 128'(lat), 128'(16));
    checkOutput("busy/state", got, {16{8'h63}});

    $display("[TB] vector table on all widths");
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 9; i++)
        runBlock(k, vecs[i].st, vecs[i].md, vecs[i].exp, $sformatf("vec%0d/k%0d", i, k), 0);

    $display("[TB] randomized blocks against the reference model");
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        md = 1'($urandom_range(0, 1));
        runBlock(k, st, md, model(st, md), $sformatf("rand%0d/k%0d", i, k), $urandom_range(0, 3));
      end

    $display("[TB] backpressure with input noise during RUN and DONE");
    applyStimulus(0, vecs[1].st, 1'b0, "bp");
    lat = 0;
    while (!out_valid[0] && lat < 200) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      in_mode[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    if (!out_valid[0]) timeoutFail("bp/result");
    checkOutput("bp/latency", 128'(lat), 128'(16));
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp/hold%0d/valid", c), 128'(out_valid[0]), 128'(1));
      checkOutput($sformatf("bp/hold%0d/state", c), out_state[0], vecs[1].exp);
      checkOutput($sformatf("bp/hold%0d/in_ready", c), 128'(in_ready[0]), 128'(0));
      in_valid[0] = 1'($urandom_range(0, 1));
      in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      in_mode[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    checkOutput("bp/final_state", out_state[0], vecs[1].exp);
    drain(0, "bp");

    $display("[TB] reset during RUN at counter 7");
    applyStimulus(0, 128'h0, 1'b0, "rst");
    repeat (7) @(negedge clk);
    checkOutput("rst/busy_before", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst/out_valid", 128'(out_valid[0]), 128'(0));
    checkOutput("rst/out_state", out_state[0], 128'(0));
    checkOutput("rst/in_ready", 128'(in_ready[0]), 128'(1));
    checkOutput("rst/busy", 128'(busy[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    checkOutput("rst/no_result", 128'(seen), 128'(0));
    runBlock(0, 128'h0, 1'b0, {16{8'h63}}, "rst/fresh", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_serial.md
Name: sub_bytes_serial

Overview:
Byte-serial AES SubBytes/InvSubBytes engine that sits directly upstream of the round's ShiftRows/MixColumns logic.
- Captures a 128-bit state through a valid/ready handshake.
- Streams it through BYTES_PER_CYCLE instances of the composite-field sbox, with ctrl = mode (0 = forward/encrypt, 1 = inverse/decrypt).
- Presents the substituted 128-bit state through a second valid/ready handshake.

Parameters:
BYTES_PER_CYCLE, 1, sbox instances used in parallel; legal values 1, 2, 4, 8, 16; N = 16/BYTES_PER_CYCLE substitution cycles.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  one clock; reset is asynchronous and active-low
in_valid  input  1  upstream offers in_state/in_mode
in_ready  output  1  engine can accept; high only in IDLE
in_state  input  128  byte i = in_state[8i+7:8i]; byte 0 is the first byte of the FIPS-197 byte string
in_mode  input  1  0 = SubBytes, 1 = InvSubBytes
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts the result
out_state  output  128  substituted state, same byte ordering
busy  output  1  high in RUN or DONE
err  output  1  self-check mismatch flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset (asynchronous, rst_n = 0):
  - FSM to IDLE; working register and out_state = 0; byte counter = 0; captured mode = 0.
  - out_valid = 0, busy = 0, err = 0.
  - in_ready = 1 as soon as the FSM is in IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture in_state into the working register and in_mode into the mode register, clear err, clear the counter, go to RUN.
  - in_valid = 0 leaves the block in IDLE.
- RUN:
  - in_ready = 0. in_state and in_mode are ignored.
  - Each edge replaces bytes [c*B .. c*B+B-1] of the working register with sbox(byte, mode), where c = counter and B = BYTES_PER_CYCLE. Bytes are processed in ascending order. Then c increments.
  - On the edge where c = N-1, go to DONE.
- Latency:
  - The accept edge is T0.
  - Substitution edges are T0+1 .. T0+N.
  - out_valid rises after edge T0+N (N = 16 for the default B = 1).
- DONE:
  - out_valid = 1. out_state = working register, held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE, out_valid falls.
  - No same-cycle re-accept: the earliest next in_ready is the cycle after DONE exits. Throughput is one block per N+2 cycles.
- out_state continuously reflects the working register. It is only meaningful while out_valid = 1; downstream must not sample it otherwise.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned, no out_valid is produced, and the block returns to the reset values.
- The sbox path is purely combinational within one cycle. There is no multicycle path.

Optional Feature:
Macro SUBBYTES_SELFCHECK_EN (fault-injection countermeasure).
- Defined:
  - Each substituted byte is fed through a second sbox instance with ctrl = ~mode, and the result is compared with the original byte in the same cycle.
  - Any mismatch sets err on that edge. err stays set (sticky) through DONE and clears only on the next accept or on reset.
  - The result is still delivered normally.
- Undefined: no checker logic is instantiated and err is tied to 0.

Test Plan:
1. Default B = 1, in_state all 0x00, in_mode = 0 → after 16 substitution edges out_valid = 1 and out_state = all 0x63. busy is high for 17 cycles with out_ready tied high.
2. in_state = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 (byte 0 first), mode 0 → out_state = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30. Repeat with that output and mode 1 → original input returned.
3. Spot bytes: 0x53 mode 0 → 0xED; 0xED mode 1 → 0x53; 0x63 mode 1 → 0x00; 0x01 mode 0 → 0x7C.
4. Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid and out_state stay stable, in_ready stays 0. Toggling in_valid/in_state/in_mode during RUN and DONE has no effect on the result.
5. Pull rst_n low at RUN counter = 7 → out_valid = 0, out_state = 0, in_ready = 1 immediately, and no result is ever emitted. A fresh all-0x00 block afterwards yields all 0x63.
6. Run with BYTES_PER_CYCLE = 4 and 16 → out_valid after 4 and 1 substitution edges respectively, same results as scenario 2. With SUBBYTES_SELFCHECK_EN defined and one checker output forced wrong, err = 1 through DONE and clears on the next accept.
